// File: rtl/pipe_sched_pkg.sv
// Shared constants and types for the round-robin fed increment pipeline.
package pipe_sched_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_STAGES = 4;

  // Per-stage increment: stage 0 is a plain load, stage k adds k.
  localparam int STG_INC [0:3] = '{0, 1, 2, 3};

  typedef logic req_id_t;

  localparam logic [2:0] HIT_PAT_A = 3'b101;
  localparam logic [2:0] HIT_PAT_B = 3'b111;

endpackage

// File: rtl/pipe_rr_sched_if.sv
// Requester, consumer and flush signals of pipe_rr_sched.
// PIPE_SCHED_RANGE_CHK_EN adds the out_hit flag.
interface pipe_rr_sched_if #(
  parameter int DATA_W = pipe_sched_pkg::DEF_DATA_W
);
  logic              flush;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_id;
  logic              out_ready;
  logic [2:0]        occupancy;
`ifdef PIPE_SCHED_RANGE_CHK_EN
  logic              out_hit;

  modport master (
    output flush, req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, occupancy, out_hit
  );

  modport slave (
    input  flush, req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, occupancy, out_hit
  );
`else
  modport master (
    output flush, req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, occupancy
  );

  modport slave (
    input  flush, req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, occupancy
  );
`endif
endinterface

// File: rtl/pipe_rr_sched_rr_arb2.sv
// Two-input round-robin arbiter; rr_ptr names the requester favoured on a tie.
module rr_arb2
  import pipe_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  logic rr_ptr;

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (en) begin
      case (req)
        2'b01: begin gnt = 2'b01; gnt_id = 1'b0; end
        2'b10: begin gnt = 2'b10; gnt_id = 1'b1; end
        2'b11: begin
          gnt_id = rr_ptr;
          gnt    = rr_ptr ? 2'b10 : 2'b01;
        end
        default: begin gnt = 2'b00; gnt_id = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (|gnt)
      rr_ptr <= ~gnt_id;
  end

endmodule

// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler feeding a 4-stage +0/+1/+2/+3 pipeline with stall and flush.
// Optional out_hit range flag: define PIPE_SCHED_RANGE_CHK_EN.
module pipe_rr_sched
  import pipe_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STAGES = DEF_STAGES
) (
  input logic             clk,
  input logic             rst,
  pipe_rr_sched_if.slave  bus
);

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a, input int inc);
    return a + DATA_W'(inc);
  endfunction

  logic              vld_p0, vld_p1, vld_p2, vld_p3;
  logic [DATA_W-1:0] d_p0, d_p1, d_p2, d_p3;
  req_id_t           id_p0, id_p1, id_p2, id_p3;

  logic              advance;
  logic              grant_en;
  logic [1:0]        gnt;
  req_id_t           gnt_id;
  logic [STAGES-1:0] vld_vec;
  logic [2:0]        occ;

  // A stall happens only when stage 3 is full and the consumer refuses it.
  assign advance  = !vld_p3 || bus.out_ready;
  assign grant_en = advance && !bus.flush && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (grant_en),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
      d_p0   <= '0;   d_p1   <= '0;   d_p2   <= '0;   d_p3   <= '0;
      id_p0  <= 1'b0; id_p1  <= 1'b0; id_p2  <= 1'b0; id_p3  <= 1'b0;
    end else begin
      if (bus.flush) begin
        vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
      end else if (advance) begin
        vld_p0 <= |gnt;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
        vld_p3 <= vld_p2;
      end
      if (advance) begin
        // stage 0: load grant winner
        d_p0  <= wrap_add(gnt[1] ? bus.req1_data : bus.req0_data, STG_INC[0]);
        id_p0 <= gnt_id;
        // stage 1
        d_p1  <= wrap_add(d_p0, STG_INC[1]);
        id_p1 <= id_p0;
        // stage 2
        d_p2  <= wrap_add(d_p1, STG_INC[2]);
        id_p2 <= id_p1;
        // stage 3
        d_p3  <= wrap_add(d_p2, STG_INC[3]);
        id_p3 <= id_p2;
      end
    end
  end

  assign vld_vec = {vld_p3, vld_p2, vld_p1, vld_p0};

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++)
      occ = occ + 3'(vld_vec[i]);
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.out_valid  = vld_p3;
  assign bus.out_data   = d_p3;
  assign bus.out_id     = id_p3;
  assign bus.occupancy  = occ;

`ifdef PIPE_SCHED_RANGE_CHK_EN
  function automatic logic is_hit(input logic [DATA_W-1:0] d);
    return (d[2:0] == HIT_PAT_A) || (d[2:0] == HIT_PAT_B);
  endfunction

  logic hit_p3;

  // Computed from the value entering stage 3 so it lines up with v3/d3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_p3 <= 1'b0;
    else if (bus.flush)
      hit_p3 <= 1'b0;
    else if (advance)
      hit_p3 <= vld_p2 && is_hit(wrap_add(d_p2, STG_INC[3]));
  end

  assign bus.out_hit = hit_p3;
`endif

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Directed bench for pipe_rr_sched: vector table plus reset, backpressure and flush sequences.
module tb_pipe_rr_sched;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_rr_sched_if #(.DATA_W(8)) bus ();

  pipe_rr_sched #(.DATA_W(8), .STAGES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r0v;
    logic [7:0] r0d;
    logic       r1v;
    logic [7:0] r1d;
    logic       ordy;
    logic       e_r0;
    logic       e_r1;
    logic       e_ov;
    logic [7:0] e_d;
    logic       e_id;
    logic [2:0] e_occ;
    logic       e_hit;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic r0v, logic [7:0] r0d, logic r1v, logic [7:0] r1d,
                              logic ordy, logic e_r0, logic e_r1, logic e_ov,
                              logic [7:0] e_d, logic e_id, logic [2:0] e_occ, logic e_hit);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d; v.ordy = ordy;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_d = e_d; v.e_id = e_id;
    v.e_occ = e_occ; v.e_hit = e_hit;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic [7:0] r0d, input logic r1v,
                       input logic [7:0] r1d, input logic ordy, input logic fl);
    bus.req0_valid = r0v;
    bus.req0_data  = r0d;
    bus.req1_valid = r1v;
    bus.req1_data  = r1d;
    bus.out_ready  = ordy;
    bus.flush      = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // contention, single requester, wrap-around
    tbl[0]  = mk(1, 8'h01, 1, 8'h81, 1, 1, 0, 0, 8'h00, 0, 3'd0, 0);
    tbl[1]  = mk(1, 8'h01, 1, 8'h81, 1, 0, 1, 0, 8'h00, 0, 3'd1, 0);
    tbl[2]  = mk(1, 8'h01, 1, 8'h81, 1, 1, 0, 0, 8'h00, 0, 3'd2, 0);
    tbl[3]  = mk(1, 8'h01, 1, 8'h81, 1, 0, 1, 0, 8'h00, 0, 3'd3, 0);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h07, 0, 3'd4, 1);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h87, 1, 3'd3, 1);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h07, 0, 3'd2, 1);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h87, 1, 3'd1, 1);
    tbl[8]  = mk(1, 8'h10, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 3'd0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd1, 0);
    tbl[10] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd1, 0);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd1, 0);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h16, 0, 3'd1, 0);
    tbl[13] = mk(0, 8'h00, 1, 8'hFF, 1, 0, 1, 0, 8'h00, 0, 3'd0, 0);
    tbl[14] = mk(1, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 3'd1, 0);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd2, 0);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd2, 0);
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h05, 1, 3'd2, 1);
    tbl[18] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h06, 0, 3'd1, 0);
    tbl[19] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd0, 0);

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    #12;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_id", 32'(bus.out_id), 32'd0);
    chk("reset occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("reset req1_ready", 32'(bus.req1_ready), 32'd0);
`ifdef PIPE_SCHED_RANGE_CHK_EN
    chk("reset out_hit", 32'(bus.out_hit), 32'd0);
`endif
    cycle();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r0v, tbl[i].r0d, tbl[i].r1v, tbl[i].r1d, tbl[i].ordy, 1'b0);
      #1;
      chk($sformatf("row%0d req0_ready", i), 32'(bus.req0_ready), 32'(tbl[i].e_r0));
      chk($sformatf("row%0d req1_ready", i), 32'(bus.req1_ready), 32'(tbl[i].e_r1));
      chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d occupancy", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].e_d));
        chk($sformatf("row%0d out_id", i), 32'(bus.out_id), 32'(tbl[i].e_id));
      end
`ifdef PIPE_SCHED_RANGE_CHK_EN
      chk($sformatf("row%0d out_hit", i), 32'(bus.out_hit), 32'(tbl[i].e_hit));
`endif
      cycle();
    end

    // reset mid-stream with three items in flight; rr_ptr was left pointing at req1
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h30 + k), 1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("midrst occupancy before", 32'(bus.occupancy), 32'd3);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst occupancy", 32'(bus.occupancy), 32'd0);
    cycle();
    rst = 1'b0;
    drive(1'b1, 8'h50, 1'b1, 8'h60, 1'b1, 1'b0);
    #1;
    chk("midrst first grant req0", 32'(bus.req0_ready), 32'd1);
    chk("midrst first grant req1", 32'(bus.req1_ready), 32'd0);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(); cycle(); cycle();
    chk("midrst new item valid", 32'(bus.out_valid), 32'd1);
    chk("midrst new item data", 32'(bus.out_data), 32'h56);
    idle(2);
    chk("midrst drained", 32'(bus.occupancy), 32'd0);

    // backpressure: fill to four, stall five cycles, then drain
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h20 + k), 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp fill%0d req0_ready", k), 32'(bus.req0_ready), 32'd1);
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'h24, 1'b1, 8'h70, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp stall%0d req0_ready", k), 32'(bus.req0_ready), 32'd0);
      chk($sformatf("bp stall%0d req1_ready", k), 32'(bus.req1_ready), 32'd0);
      chk($sformatf("bp stall%0d occupancy", k), 32'(bus.occupancy), 32'd4);
      chk($sformatf("bp stall%0d out_data", k), 32'(bus.out_data), 32'h26);
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      chk($sformatf("bp pop%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp pop%0d out_data", k), 32'(bus.out_data), 32'(8'h26 + k));
      chk($sformatf("bp pop%0d occupancy", k), 32'(bus.occupancy), 32'(4 - k));
      cycle();
    end
    chk("bp empty out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp empty occupancy", 32'(bus.occupancy), 32'd0);

    // flush with three in flight while req1 waits
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h90 + k), 1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b1);
    #1;
    chk("flush req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("flush occupancy before", 32'(bus.occupancy), 32'd3);
    cycle();
    drive(1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0);
    #1;
    chk("flush occupancy after", 32'(bus.occupancy), 32'd0);
    chk("flush req1 granted", 32'(bus.req1_ready), 32'd1);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("flush refill occupancy", 32'(bus.occupancy), 32'd1);
    cycle(); cycle(); cycle();
    chk("flush req1 item valid", 32'(bus.out_valid), 32'd1);
    chk("flush req1 item data", 32'(bus.out_data), 32'h46);
    chk("flush req1 item id", 32'(bus.out_id), 32'd1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
